// File: rtl/exe_hazard_fwd_ctrl.sv
// Execute-stage hazard controller: tracks EXE/MEM writers, registers operand
// forwarding selects, raises load-use/RAW stalls and the branch flush.
module exe_hazard_fwd_ctrl #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             fwd_en,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             id_src2_is_store,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             br_taken,
    output logic [1:0]       val1_sel,
    output logic [1:0]       val2_sel,
    output logic [1:0]       src2_val_sel,
    output logic             hazard_stall,
    output logic             flush
);

    // WB-stage occupancy and the MEM load flag are never consulted: a MEM
    // writer is forwarded from WB one cycle later, decided here from MEM.
    logic [REG_W-1:0] e_dest_q, e_dest_d;
    logic             e_wb_en_q, e_wb_en_d;
    logic             e_mem_r_en_q, e_mem_r_en_d;
    logic [REG_W-1:0] m_dest_q, m_dest_d;
    logic             m_wb_en_q, m_wb_en_d;
    logic [1:0]       val1_sel_q, val1_sel_d;
    logic [1:0]       val2_sel_q, val2_sel_d;
    logic [1:0]       src2_val_sel_q, src2_val_sel_d;

    logic [REG_W-1:0] src [2];
    logic [1:0]       used;
    logic [1:0]       hit_e;
    logic [1:0]       hit_m;
    logic [1:0]       nsel [2];
    logic             stall_raw;
    logic             bubble;

    assign src[0]  = id_src1;
    assign src[1]  = id_src2;
    assign used[0] = id_valid;
    assign used[1] = id_valid & (id_two_src | id_src2_is_store);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign hit_e[gi] = e_wb_en_q && (e_dest_q == src[gi]) && (src[gi] != '0);
            assign hit_m[gi] = m_wb_en_q && (m_dest_q == src[gi]) && (src[gi] != '0);
            // The EXE writer is the younger producer, so it takes priority.
            assign nsel[gi]  = (!used[gi] || !fwd_en) ? 2'b00 :
                               hit_e[gi]              ? 2'b01 :
                               hit_m[gi]              ? 2'b10 : 2'b00;
        end
    endgenerate

    always_comb begin
        stall_raw = 1'b0;
        if (fwd_en) begin
            stall_raw = |(used & hit_e) & e_mem_r_en_q;
        end else begin
            stall_raw = |(used & (hit_e | hit_m));
        end
    end

    assign hazard_stall = stall_raw & ~br_taken;
    assign flush        = br_taken;
    assign bubble       = flush | hazard_stall | ~id_valid;

    always_comb begin
        m_dest_d       = e_dest_q;
        m_wb_en_d      = e_wb_en_q;
        e_dest_d       = '0;
        e_wb_en_d      = 1'b0;
        e_mem_r_en_d   = 1'b0;
        val1_sel_d     = 2'b00;
        val2_sel_d     = 2'b00;
        src2_val_sel_d = 2'b00;
        if (!bubble) begin
            e_dest_d       = id_dest;
            e_wb_en_d      = id_wb_en;
            e_mem_r_en_d   = id_mem_r_en;
            val1_sel_d     = nsel[0];
            val2_sel_d     = id_two_src       ? nsel[1] : 2'b00;
            src2_val_sel_d = id_src2_is_store ? nsel[1] : 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_dest_q       <= '0;
            e_wb_en_q      <= 1'b0;
            e_mem_r_en_q   <= 1'b0;
            m_dest_q       <= '0;
            m_wb_en_q      <= 1'b0;
            val1_sel_q     <= 2'b00;
            val2_sel_q     <= 2'b00;
            src2_val_sel_q <= 2'b00;
        end else if (!freeze) begin
            e_dest_q       <= e_dest_d;
            e_wb_en_q      <= e_wb_en_d;
            e_mem_r_en_q   <= e_mem_r_en_d;
            m_dest_q       <= m_dest_d;
            m_wb_en_q      <= m_wb_en_d;
            val1_sel_q     <= val1_sel_d;
            val2_sel_q     <= val2_sel_d;
            src2_val_sel_q <= src2_val_sel_d;
        end
    end

    assign val1_sel     = val1_sel_q;
    assign val2_sel     = val2_sel_q;
    assign src2_val_sel = src2_val_sel_q;

endmodule

// File: tb/tb_exe_hazard_fwd_ctrl.sv
// Randomized bench: a pipeline-occupancy model predicts each cycle's outputs,
// a scoreboard queue carries them to a monitor that compares at negedge.
module tb_exe_hazard_fwd_ctrl;
    localparam int REG_W  = 5;
    localparam int N_CYC  = 600;

    logic             clk = 1'b0;
    logic             rst, freeze, fwd_en, id_valid;
    logic [REG_W-1:0] id_src1, id_src2, id_dest;
    logic             id_two_src, id_src2_is_store, id_wb_en, id_mem_r_en, br_taken;
    logic [1:0]       val1_sel, val2_sel, src2_val_sel;
    logic             hazard_stall, flush;

    always #5 clk = ~clk;

    exe_hazard_fwd_ctrl #(.REG_W(REG_W)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .fwd_en(fwd_en),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_src2_is_store(id_src2_is_store),
        .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
        .br_taken(br_taken), .val1_sel(val1_sel), .val2_sel(val2_sel),
        .src2_val_sel(src2_val_sel), .hazard_stall(hazard_stall), .flush(flush)
    );

    typedef struct packed {
        logic             wb;
        logic             ld;
        logic [REG_W-1:0] dest;
    } instr_t;

    typedef struct packed {
        logic [1:0] v1;
        logic [1:0] v2;
        logic [1:0] sv;
        logic       st;
        logic       fl;
    } exp_t;

    instr_t     pipe [2];     // [0] = instruction in EXE, [1] = in MEM
    logic [1:0] sel_m [3];    // selects currently held for the EXE instruction
    exp_t       sb_q [$];
    int         checks   = 0;
    int         failures = 0;
    bit         stim_done = 1'b0;

    // Distance back to the youngest in-flight writer of s (0 = none).
    function automatic int producer_dist(input logic [REG_W-1:0] s);
        if (s == '0) return 0;
        for (int k = 0; k < 2; k++)
            if (pipe[k].wb && pipe[k].dest == s) return k + 1;
        return 0;
    endfunction

    function automatic logic [1:0] sel_for(input int d);
        if (d == 1) return 2'b01;
        if (d == 2) return 2'b10;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
        end
    endtask

    // Stimulus and model.
    initial begin
        bit   hold;
        int   d1, d2;
        bit   load_hit;
        exp_t e;
        rst = 1'b1; freeze = 1'b0; fwd_en = 1'b1; id_valid = 1'b0;
        id_src1 = '0; id_src2 = '0; id_dest = '0; id_two_src = 1'b0;
        id_src2_is_store = 1'b0; id_wb_en = 1'b0; id_mem_r_en = 1'b0; br_taken = 1'b0;
        for (int k = 0; k < 2; k++) pipe[k] = '0;
        for (int k = 0; k < 3; k++) sel_m[k] = 2'b00;
        hold = 1'b0;
        @(posedge clk);
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(posedge clk);
            #1;
            rst      = (cyc < 2) || ($urandom_range(0, 99) < 3);
            freeze   = (cyc == 1) || ($urandom_range(0, 99) < 15);
            fwd_en   = (cyc < 300) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 40);
            br_taken = ($urandom_range(0, 99) < 12);
            if (!hold) begin
                id_valid         = ($urandom_range(0, 99) < 85);
                id_src1          = REG_W'($urandom_range(0, 3));
                id_src2          = REG_W'($urandom_range(0, 3));
                id_dest          = REG_W'($urandom_range(0, 3));
                id_two_src       = 1'($urandom_range(0, 1));
                id_src2_is_store = 1'($urandom_range(0, 1));
                id_wb_en         = ($urandom_range(0, 99) < 70);
                id_mem_r_en      = ($urandom_range(0, 99) < 35);
            end

            d1 = id_valid ? producer_dist(id_src1) : 0;
            d2 = (id_valid && (id_two_src || id_src2_is_store)) ? producer_dist(id_src2) : 0;
            load_hit = pipe[0].ld && (d1 == 1 || d2 == 1);
            e.st = (fwd_en ? load_hit : (d1 != 0 || d2 != 0)) && !br_taken;
            e.fl = br_taken;
            e.v1 = sel_m[0];
            e.v2 = sel_m[1];
            e.sv = sel_m[2];
            sb_q.push_back(e);
            $display("cyc=%0d rst=%0b frz=%0b fwd=%0b v=%0b s1=%0d s2=%0d d=%0d wb=%0b ld=%0b br=%0b exp_st=%0b sel=%0b/%0b/%0b",
                     cyc, rst, freeze, fwd_en, id_valid, id_src1, id_src2, id_dest,
                     id_wb_en, id_mem_r_en, br_taken, e.st, e.v1, e.v2, e.sv);

            if (rst) begin
                for (int k = 0; k < 2; k++) pipe[k] = '0;
                for (int k = 0; k < 3; k++) sel_m[k] = 2'b00;
            end else if (!freeze) begin
                pipe[1] = pipe[0];
                if (br_taken || e.st || !id_valid) begin
                    pipe[0] = '0;
                    for (int k = 0; k < 3; k++) sel_m[k] = 2'b00;
                end else begin
                    pipe[0] = '{wb: id_wb_en, ld: id_mem_r_en, dest: id_dest};
                    sel_m[0] = fwd_en ? sel_for(d1) : 2'b00;
                    sel_m[1] = (fwd_en && id_two_src) ? sel_for(d2) : 2'b00;
                    sel_m[2] = (fwd_en && id_src2_is_store) ? sel_for(d2) : 2'b00;
                end
            end
            hold = (e.st || freeze) && !rst;
        end
        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0 pending", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                chk("val1_sel", val1_sel, x.v1);
                chk("val2_sel", val2_sel, x.v2);
                chk("src2_val_sel", src2_val_sel, x.sv);
                chk("hazard_stall", {1'b0, hazard_stall}, {1'b0, x.st});
                chk("flush", {1'b0, flush}, {1'b0, x.fl});
            end
        end
    end

    // Hard time limit in case the clock or stimulus stalls.
    initial begin
        #(20 * N_CYC * 10);
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/exe_hazard_fwd_ctrl.md
# exe_hazard_fwd_ctrl

Pipeline controller for the execute stage. It tracks the destination and write-back state of the instructions in the EXE, MEM and WB stages and issues three outputs: registered forwarding selects for the EXE operand muxes, a load-use/RAW stall request to IF/ID, and a branch flush. It sits beside the ID/EXE pipeline register. It consumes decoded ID-stage fields and the EXE branch decision.

## Interface
- `REG_W`, default 5: register index width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `freeze` in 1: global pipeline hold (memory wait). All internal state holds.
- `fwd_en` in 1: 1 enables forwarding. 0 stalls on every RAW hazard instead.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_src1`, `id_src2` in REG_W: ID source registers.
- `id_two_src` in 1: `id_src2` feeds ALU operand 2.
- `id_src2_is_store` in 1: `id_src2` feeds the store/compare value path.
- `id_dest` in REG_W: ID destination register.
- `id_wb_en` in 1: the ID instruction writes the register file.
- `id_mem_r_en` in 1: the ID instruction is a load.
- `br_taken` in 1: EXE-stage branch resolved taken.
- `val1_sel`, `val2_sel`, `src2_val_sel` out 2: EXE operand selects.
  - 00 = pipeline value
  - 01 = EXE/MEM ALU result
  - 10 = WB write value
  - 11 = never driven
- `hazard_stall` out 1: hold PC and IF/ID, and insert a bubble into EXE.
- `flush` out 1: squash IF/ID and insert a bubble into EXE.

## Operation
- Tracking registers per stage: `{dest, wb_en, mem_r_en}` for `e_*` (instruction in EXE), `m_*` (MEM) and `w_*` (WB).
- A source is "used":
  - `src1` when `id_valid`.
  - `src2` when `id_valid & (id_two_src | id_src2_is_store)`.
  - Register 0 is never a hazard and is never forwarded.
- Match terms:
  - `hitE(s)` = `e_wb_en & e_dest==s & s!=0`
  - `hitM(s)` = `m_wb_en & m_dest==s & s!=0`
- `hazard_stall`, combinational:
  - `fwd_en=1`: any used source with `hitE & e_mem_r_en` (load-use).
  - `fwd_en=0`: any used source with `hitE | hitM`.
  - Forced 0 when `br_taken=1`.
- `flush` = `br_taken`, combinational.
- Next-select for a used source, priority order:
  - `hitE` → 01 (the value will be at EXE/MEM next cycle)
  - else `hitM` → 10
  - else 00
  - Unused source or `fwd_en=0` → 00.
  - `val1_sel` uses src1. `val2_sel` uses src2 gated by `id_two_src`. `src2_val_sel` uses src2 gated by `id_src2_is_store`.
- Per-cycle update when `rst=0` and `freeze=0`:
  - `w_*` ← `m_*`; `m_*` ← `e_*`.
  - If `flush | hazard_stall | !id_valid`: `e_*` ← bubble `{0,0,0}` and all selects ← 00.
  - Otherwise: `e_*` ← ID fields and selects ← next-selects.
- `freeze=1`: every register holds. `hazard_stall` and `flush` are still computed from current values.
- Simultaneous `br_taken` and a stall condition: the flush wins, a bubble is inserted, and `hazard_stall` reads 0.
- `rst=1` wins over `freeze`.
  - All tracking registers are set to 0 and all selects to 00.
  - `hazard_stall` therefore reads 0 (given `br_taken=0`).
  - `flush` follows `br_taken`.

## Timing
- Selects are registered. They are valid during the cycle the instruction is in EXE, one cycle after it was presented in ID.
- A load followed directly by a dependent instruction:
  - One stall cycle.
  - The dependent instruction then enters EXE with select 10 (the load value is in WB).
- `fwd_en=0`: up to two stall cycles per dependency. Selects are always 00.
- A stall or flush decision affects the registers at the next rising edge. The ID inputs must stay stable during a stall (IF/ID holds).
- Reset value of every output:
  - Selects 00.
  - `hazard_stall` 0.
  - `flush` = `br_taken`.

## Test plan
- **ALU forwarding:** `fwd_en=1`, cycle 0 `add r3` (`id_dest=3`, `id_wb_en=1`), cycle 1 `id_src1=3` → cycle 2 `val1_sel=01`, no stall. With one independent instruction between them → `val1_sel=10`.
- **Load-use:** load to r5 then `id_src2=5`, `id_two_src=1` → `hazard_stall=1` for exactly one cycle, bubble in EXE, then `val2_sel=10`. With `fwd_en=0` → stall of two cycles, then selects 00.
- **Register 0:** writer with `id_dest=0`, reader with `src1=0` → no stall, `val1_sel=00`.
- **Store path:** `id_src2_is_store=1`, `id_two_src=0`, src2 matching the EXE writer → `src2_val_sel=01`, `val2_sel=00`.
- **Branch:** `br_taken=1` while a load-use condition is present → `flush=1`, `hazard_stall=0`, next-cycle `e_wb_en=0` (a following reader of that dest gets select 00).
- **Freeze/reset:** `freeze=1` for 3 cycles mid-dependency → selects and tracking hold, then resume identically. `rst=1` asserted together with `freeze=1` → all selects 00 next cycle.
